// File: rtl/fb_plot.sv
// Pixel sink: buffers plotted points in a small FIFO and drains them into a
// 1-bit-per-pixel framebuffer write port, sweeping the buffer clear on request.
module fb_plot #(
    parameter int OUT_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int HOLD_MARGIN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [OUT_WIDTH-1:0]   xout,
    input  logic [OUT_WIDTH-1:0]   yout,
    input  logic                   line_busy,
    input  logic                   frame_start,
    output logic                   hold,
    output logic                   fb_we,
    output logic [2*OUT_WIDTH-1:0] fb_addr,
    output logic                   fb_data,
    output logic                   frame_done,
    output logic                   ovf
);
    localparam int AW = 2 * OUT_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [PW-1:0] PTR_ONE   = 1;
    localparam logic [CW-1:0] OCC_ONE   = 1;
    localparam logic [CW-1:0] OCC_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] OCC_HOLD  = CW'(FIFO_DEPTH - HOLD_MARGIN);

    typedef enum logic {ST_CLEAR = 1'b0, ST_PLOT = 1'b1} state_t;

    state_t          state, state_n;
    logic [AW:0]     cnt, cnt_n;      // MSB set means the sweep has passed the last address
    logic            pending, pending_n;

    logic [AW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   occ;
    logic            empty, full, pop, push, start_clear;

    logic            we_n, data_n, done_n;
    logic [AW-1:0]   addr_n;

    assign empty       = (occ == '0);
    assign full        = (occ == OCC_FULL);
    assign start_clear = (state == ST_PLOT) && pending && empty && !line_busy;
    assign pop         = (state == ST_PLOT) && !empty;
    assign push        = wr && (!full || pop);
    assign hold        = (state == ST_CLEAR) || pending || (occ >= OCC_HOLD);

    // Pixel FIFO storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {yout, xout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      occ <= occ + OCC_ONE;
            else if (!push && pop) occ <= occ - OCC_ONE;
            if (wr && full && !pop) ovf <= 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pending <= pending_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n   = state;
        pending_n = pending;
        case (state)
            ST_CLEAR: begin
                pending_n = 1'b0;
                if (cnt[AW]) state_n = ST_PLOT;
            end
            ST_PLOT: begin
                if (start_clear) begin
                    state_n   = ST_CLEAR;
                    pending_n = 1'b0;
                end else if (frame_start) begin
                    pending_n = 1'b1;
                end
            end
            default: state_n = ST_CLEAR;
        endcase
    end

    // Output logic: next values of the registered write port and sweep counter
    always_comb begin
        we_n   = 1'b0;
        data_n = fb_data;
        addr_n = fb_addr;
        done_n = 1'b0;
        cnt_n  = cnt;
        case (state)
            ST_CLEAR: begin
                if (!cnt[AW]) begin
                    we_n   = 1'b1;
                    data_n = 1'b0;
                    addr_n = cnt[AW-1:0];
                    cnt_n  = cnt + CNT_ONE;
                end else begin
                    done_n = 1'b1;
                    cnt_n  = '0;
                end
            end
            ST_PLOT: begin
                if (pop) begin
                    we_n   = 1'b1;
                    data_n = 1'b1;
                    addr_n = mem[rd_ptr];
                end else if (start_clear) begin
                    // The first clear write issues on the transition edge itself.
                    we_n   = 1'b1;
                    data_n = 1'b0;
                    addr_n = '0;
                    cnt_n  = CNT_ONE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= we_n;
            fb_addr    <= addr_n;
            fb_data    <= data_n;
            frame_done <= done_n;
        end
    end
endmodule

// File: tb/tb_fb_plot.sv
// Scoreboard bench for fb_plot: expected framebuffer writes are queued by the
// stimulus side and checked in order by a monitor on the falling edge.
module tb_fb_plot;
    localparam int W     = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2 * W;
    localparam int NPIX  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0, line_busy = 1'b0, frame_start = 1'b0;
    logic [W-1:0]  xout = '0, yout = '0;
    logic          hold, fb_we, fb_data, frame_done, ovf;
    logic [AW-1:0] fb_addr;

    fb_plot #(.OUT_WIDTH(W), .FIFO_DEPTH(DEPTH), .HOLD_MARGIN(2)) dut (
        .clk(clk), .rst(rst), .wr(wr), .xout(xout), .yout(yout),
        .line_busy(line_busy), .frame_start(frame_start), .hold(hold),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_done(frame_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic [AW:0] exp_q[$];          // {data, addr}
    int plot_cyc_q[$];
    int clear_cnt = 0, clear_first_cyc = 0, done_cnt = 0;
    logic hold_seen = 1'b0, hold_at_done = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic last_clear = 1'b0;
    int clr_pix = 0;                // pixels offered while a clear is running

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            hold_seen = hold_seen | hold;
            if (fb_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {fb_data, fb_addr}, -1);
                end else begin
                    logic [AW:0] e;
                    e = exp_q.pop_front();
                    check("write", {fb_data, fb_addr}, e);
                end
                last_addr  = fb_addr;
                last_clear = !fb_data;
                if (!fb_data) begin
                    if (clear_cnt == 0) clear_first_cyc = cyc;
                    clear_cnt++;
                end else begin
                    plot_cyc_q.push_back(cyc);
                end
            end
            if (frame_done) begin
                done_cnt++;
                hold_at_done = hold;
                check("clear_writes", clear_cnt, NPIX);
                check("done_after_last", cyc - clear_first_cyc, NPIX);
                clear_cnt = 0;
            end
        end
    end

    task automatic expect_clear();
        for (int a = 0; a < NPIX; a++) exp_q.push_back({1'b0, AW'(a)});
        clr_pix = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // One-cycle pixel strobe; in_clear applies the FIFO capacity limit.
    task automatic plot(input logic [W-1:0] x, input logic [W-1:0] y, input bit in_clear);
        tick();
        wr = 1'b1; xout = x; yout = y;
        if (!in_clear) exp_q.push_back({1'b1, y, x});
        else begin
            if (clr_pix < DEPTH) exp_q.push_back({1'b1, y, x});
            clr_pix++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            wr = 1'b0; frame_start = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int start, n;
        start = done_cnt; n = 0;
        while (done_cnt == start && n < budget) begin
            @(posedge clk); n++;
        end
        #1;
        check("frame_done_seen", done_cnt - start, 1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; wr = 1'b0; frame_start = 1'b0; line_busy = 1'b0;
        idle(2);
        exp_q.delete(); plot_cyc_q.delete(); clear_cnt = 0;
        @(negedge clk);
        check("rst_fb_we", fb_we, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_frame_done", frame_done, 0);
        tick();
        rst = 1'b0;
        expect_clear();
        @(negedge clk);
        check("post_rst_fb_we", fb_we, 0);
        check("post_rst_hold", hold, 1);
        check("post_rst_ovf", ovf, 0);
        check("post_rst_addr", fb_addr, 0);
    endtask

    initial begin
        int c, lcyc, n;
        // Reset clear sweep
        do_reset();
        wait_done(400);
        check("hold_after_clear", hold_at_done, 0);

        // Single pixel latency
        idle(3);
        plot(4'd3, 4'd5, 1'b0);
        c = cyc;
        idle(1);
        tick();
        @(negedge clk);
        check("lat_cycle", cyc, c + 2);
        check("lat_we", fb_we, 1);
        check("lat_addr", fb_addr, 8'h53);
        check("lat_data", fb_data, 1);
        @(negedge clk);
        check("lat_we_off", fb_we, 0);

        // Back-to-back burst of 20 random pixels
        idle(2);
        plot_cyc_q.delete();
        hold_seen = 1'b0;
        for (int i = 0; i < 20; i++) plot(W'($urandom), W'($urandom), 1'b0);
        idle(5);
        check("burst_count", plot_cyc_q.size(), 20);
        if (plot_cyc_q.size() == 20) check("burst_gapless", plot_cyc_q[19] - plot_cyc_q[0], 19);
        check("burst_hold", hold_seen, 0);
        check("burst_ovf", ovf, 0);

        // Random sparse pixels with random line_busy
        for (int i = 0; i < 40; i++) begin
            tick();
            line_busy = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            xout = W'($urandom); yout = W'($urandom);
            if (wr) exp_q.push_back({1'b1, yout, xout});
        end
        idle(5);
        check("rand_drained", exp_q.size(), 0);

        // Deferred clear
        line_busy = 1'b1;
        plot(4'd1, 4'd2, 1'b0);
        plot(4'd7, 4'd9, 1'b0);
        plot(4'd15, 4'd0, 1'b0);
        frame_start = 1'b1;
        expect_clear();
        tick();
        wr = 1'b0;
        frame_start = 1'b1;           // repeated request while pending
        @(negedge clk);
        check("defer_hold", hold, 1);
        idle(10);
        check("defer_no_clear", clear_cnt, 0);
        check("defer_pixels_done", exp_q.size(), NPIX);
        line_busy = 1'b0;
        lcyc = cyc;
        wait_done(400);
        check("defer_clear_start", clear_first_cyc, lcyc + 1);

        // Overflow during clear
        do_reset();
        idle(8);
        for (int k = 1; k <= 6; k++) begin
            plot(W'($urandom), W'($urandom), 1'b1);
            @(negedge clk);
            check("ovf_progress", ovf, (k - 1 >= 5) ? 1 : 0);
        end
        idle(1);
        @(negedge clk);
        check("ovf_set", ovf, 1);
        check("ovf_hold", hold, 1);
        plot_cyc_q.delete();
        wait_done(400);
        idle(10);
        check("ovf_plot_count", plot_cyc_q.size(), 4);
        check("ovf_sb_empty", exp_q.size(), 0);

        // Reset mid-clear at 0x40
        do_reset();
        for (int k = 0; k < 6; k++) plot(W'($urandom), W'($urandom), 1'b1);
        idle(1);
        n = 0;
        while (!(last_clear && last_addr == 8'h40) && n < 400) begin
            @(negedge clk); n++;
        end
        check("reached_0x40", last_addr, 8'h40);
        check("mid_ovf_before", ovf, 1);
        do_reset();
        plot_cyc_q.delete();
        wait_done(400);
        idle(10);
        check("mid_fifo_empty", plot_cyc_q.size(), 0);
        check("mid_hold_after", hold_at_done, 0);
        check("mid_ovf_after", ovf, 0);
        check("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
